// File: rtl/avalon_st_slave_wrapper.sv
// Avalon-ST responder: collects operand packets A and B on the sink, then
// returns their unsigned 64-bit product as an 8-beat packet on the source.
module avalon_st_slave_wrapper #(
  parameter logic [7:0] TAG_A = 8'd1,
  parameter logic [7:0] TAG_B = 8'd2
) (
  input  logic        clk,
  input  logic        _rst,
  input  logic        valid_in,
  input  logic        startofpacket_in,
  input  logic        endofpacket_in,
  input  logic [7:0]  data_in,
  output logic        ready_out,
  input  logic        ready_in,
  output logic        valid_out,
  output logic        startofpacket_out,
  output logic        endofpacket_out,
  output logic [7:0]  data_out,
  output logic [63:0] RES,
  output logic        res_done,
  output logic        pkt_err
);

  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_DATA = 2'd1;
  localparam logic [1:0] RX_DROP = 2'd2;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_LOAD = 2'd1;
  localparam logic [1:0] TX_SEND = 2'd2;

  logic [1:0]  rx_state;
  logic [1:0]  tx_state;
  logic [1:0]  cnt;
  logic        tag_is_b;
  logic [23:0] stage;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic        have_a;
  logic        have_b;
  logic [55:0] shift_reg;
  logic [2:0]  beat;

  logic        sink_fire;
  logic        tag_ok;
  logic        op_done;
  logic        write_a;
  logic        write_b;
  logic        start_tx;
  logic [63:0] product;

  assign sink_fire = valid_in & ready_out;
  assign tag_ok    = (data_in == TAG_A) || (data_in == TAG_B);
  assign op_done   = sink_fire && (rx_state == RX_DATA) && !startofpacket_in &&
                     (cnt == 2'd3) && endofpacket_in;
  assign write_a   = op_done && !tag_is_b;
  assign write_b   = op_done && tag_is_b;
  assign start_tx  = op_done && (have_a || write_a) && (have_b || write_b);
  assign product   = {32'd0, a_reg} * {32'd0, b_reg};

  // Sink side: header decode, operand byte staging and malformed-packet dropping.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      rx_state <= RX_IDLE;
      cnt      <= 2'd0;
      tag_is_b <= 1'b0;
      stage    <= 24'd0;
      a_reg    <= 32'd0;
      b_reg    <= 32'd0;
      pkt_err  <= 1'b0;
    end else begin
      pkt_err <= 1'b0;
      if (sink_fire) begin
        case (rx_state)
          RX_IDLE: begin
            if (startofpacket_in) begin
              if (tag_ok) begin
                rx_state <= RX_DATA;
                cnt      <= 2'd0;
                tag_is_b <= (data_in == TAG_B);
              end else begin
                rx_state <= RX_DROP;
                pkt_err  <= 1'b1;
              end
            end
          end
          RX_DATA: begin
            if (startofpacket_in) begin
              pkt_err <= 1'b1;
              if (tag_ok) begin
                rx_state <= RX_DATA;
                cnt      <= 2'd0;
                tag_is_b <= (data_in == TAG_B);
              end else begin
                rx_state <= RX_DROP;
              end
            end else if (cnt == 2'd3) begin
              if (endofpacket_in) begin
                if (tag_is_b) b_reg <= {stage, data_in};
                else          a_reg <= {stage, data_in};
                rx_state <= RX_IDLE;
              end else begin
                pkt_err  <= 1'b1;
                rx_state <= RX_DROP;
              end
            end else if (endofpacket_in) begin
              pkt_err  <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              stage <= {stage[15:0], data_in};
              cnt   <= cnt + 2'd1;
            end
          end
          default: begin
            if (endofpacket_in) rx_state <= RX_IDLE;
          end
        endcase
      end
    end
  end

  // Operand flags, sink backpressure and the result packet sequencer.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      tx_state          <= TX_IDLE;
      have_a            <= 1'b0;
      have_b            <= 1'b0;
      ready_out         <= 1'b1;
      valid_out         <= 1'b0;
      startofpacket_out <= 1'b0;
      endofpacket_out   <= 1'b0;
      data_out          <= 8'd0;
      RES               <= 64'd0;
      res_done          <= 1'b0;
      shift_reg         <= 56'd0;
      beat              <= 3'd0;
    end else begin
      res_done <= 1'b0;
      if (write_a) have_a <= 1'b1;
      if (write_b) have_b <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (start_tx) begin
            ready_out <= 1'b0;
            tx_state  <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          RES               <= product;
          shift_reg         <= product[55:0];
          data_out          <= product[63:56];
          valid_out         <= 1'b1;
          startofpacket_out <= 1'b1;
          endofpacket_out   <= 1'b0;
          beat              <= 3'd0;
          tx_state          <= TX_SEND;
        end
        TX_SEND: begin
          if (ready_in) begin
            if (beat == 3'd7) begin
              valid_out         <= 1'b0;
              startofpacket_out <= 1'b0;
              endofpacket_out   <= 1'b0;
              data_out          <= 8'd0;
              res_done          <= 1'b1;
              have_a            <= 1'b0;
              have_b            <= 1'b0;
              ready_out         <= 1'b1;
              tx_state          <= TX_IDLE;
            end else begin
              beat              <= beat + 3'd1;
              data_out          <= shift_reg[55:48];
              shift_reg         <= {shift_reg[47:0], 8'd0};
              startofpacket_out <= 1'b0;
              endofpacket_out   <= (beat == 3'd6);
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_st_slave_wrapper.sv
// Randomized bench for avalon_st_slave_wrapper, checked against a packet-level
// model of operand capture and the product it should return.
module tb_avalon_st_slave_wrapper;

  localparam logic [7:0] TAG_A = 8'd1;
  localparam logic [7:0] TAG_B = 8'd2;

  logic        clk = 1'b0;
  logic        _rst;
  logic        valid_in, startofpacket_in, endofpacket_in;
  logic [7:0]  data_in;
  logic        ready_out, ready_in;
  logic        valid_out, startofpacket_out, endofpacket_out;
  logic [7:0]  data_out;
  logic [63:0] RES;
  logic        res_done, pkt_err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int res_seen = 0;

  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  bit          m_have_a = 0, m_have_b = 0;

  always #5 clk = ~clk;

  avalon_st_slave_wrapper #(.TAG_A(TAG_A), .TAG_B(TAG_B)) dut (
    .clk(clk), ._rst(_rst),
    .valid_in(valid_in), .startofpacket_in(startofpacket_in),
    .endofpacket_in(endofpacket_in), .data_in(data_in), .ready_out(ready_out),
    .ready_in(ready_in), .valid_out(valid_out),
    .startofpacket_out(startofpacket_out), .endofpacket_out(endofpacket_out),
    .data_out(data_out), .RES(RES), .res_done(res_done), .pkt_err(pkt_err)
  );

  always @(negedge clk) begin
    if (pkt_err)  err_seen++;
    if (res_done) res_seen++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_ready_out"}, 64'(ready_out), 64'd1);
    checkOutput({tag, "_valid_out"}, 64'(valid_out), 64'd0);
    checkOutput({tag, "_sop_out"}, 64'(startofpacket_out), 64'd0);
    checkOutput({tag, "_eop_out"}, 64'(endofpacket_out), 64'd0);
    checkOutput({tag, "_data_out"}, 64'(data_out), 64'd0);
    checkOutput({tag, "_RES"}, RES, 64'd0);
    checkOutput({tag, "_res_done"}, 64'(res_done), 64'd0);
    checkOutput({tag, "_pkt_err"}, 64'(pkt_err), 64'd0);
  endtask

  // One sink beat, preceded by optional idle cycles, held until the DUT accepts it.
  task automatic send_beat(input bit sop, input bit eop, input logic [7:0] d);
    int budget = 200;
    bit rdy;
    bit ok = 0;
    repeat ($urandom_range(0, 1)) begin
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = 8'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    valid_in = 1'b1;
    startofpacket_in = sop;
    endofpacket_in   = eop;
    data_in = d;
    while (budget > 0) begin
      rdy = ready_out;
      @(posedge clk);
      if (rdy) begin
        ok = 1;
        break;
      end
      budget--;
      @(negedge clk);
    end
    checkOutput("sink_accept", 64'(ok), 64'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] tag, input logic [31:0] val, input int nbytes);
    logic [31:0] v;
    v = val;
    send_beat(1'b1, 1'b0, tag);
    for (int i = 0; i < nbytes; i++)
      send_beat(1'b0, i == nbytes - 1, v[31 - 8*i -: 8]);
  endtask

  // Consumes result beats under the chosen ready_in pattern until 'stop' are accepted.
  task automatic collect(input logic [63:0] exp, input int mode, input int stop);
    int idx = 0;
    int cyc = 0;
    while (idx < stop && cyc < 200) begin
      @(negedge clk);
      case (mode)
        0:       ready_in = 1'b1;
        1:       ready_in = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ready_in = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      checkOutput("tx_ready_out_low", 64'(ready_out), 64'd0);
      checkOutput("tx_valid", 64'(valid_out), 64'd1);
      checkOutput("tx_data", 64'(data_out), 64'(exp[63 - 8*idx -: 8]));
      checkOutput("tx_sop", 64'(startofpacket_out), 64'(idx == 0));
      checkOutput("tx_eop", 64'(endofpacket_out), 64'(idx == 7));
      if (valid_out && ready_in) idx++;
    end
    checkOutput("tx_beats", 64'(idx), 64'(stop));
    if (stop == 8) begin
      @(negedge clk);
      checkOutput("done_res_done", 64'(res_done), 64'd1);
      checkOutput("done_valid", 64'(valid_out), 64'd0);
      checkOutput("done_sop", 64'(startofpacket_out), 64'd0);
      checkOutput("done_eop", 64'(endofpacket_out), 64'd0);
      checkOutput("done_data", 64'(data_out), 64'd0);
      checkOutput("done_ready_out", 64'(ready_out), 64'd1);
      checkOutput("done_RES", RES, exp);
    end
  endtask

  // Packet-level model: a packet counts only with a known tag and exactly 4 data bytes.
  task automatic run_packet(input logic [7:0] tag, input logic [31:0] val, input int nbytes,
                            input int mode, input int stop);
    int err0, res0;
    bit exp_err, exp_res;
    logic [63:0] exp_prod;
    err0 = err_seen;
    res0 = res_seen;
    exp_err = 0;
    exp_res = 0;
    if (tag != TAG_A && tag != TAG_B) exp_err = 1;
    else if (nbytes != 4) exp_err = 1;
    else begin
      if (tag == TAG_A) begin m_a = val; m_have_a = 1; end
      else              begin m_b = val; m_have_b = 1; end
      exp_res = m_have_a && m_have_b;
    end
    exp_prod = {32'd0, m_a} * {32'd0, m_b};
    applyStimulus(tag, val, nbytes);
    @(negedge clk);
    valid_in = 1'b0;
    startofpacket_in = 1'b0;
    endofpacket_in = 1'b0;
    checkOutput("ready_after_pkt", 64'(ready_out), exp_res ? 64'd0 : 64'd1);
    checkOutput("valid_after_pkt", 64'(valid_out), 64'd0);
    if (exp_res) begin
      collect(exp_prod, mode, stop);
      m_have_a = 0;
      m_have_b = 0;
    end
    if (stop == 8) begin
      @(negedge clk);
      checkOutput("pkt_err_count", 64'(err_seen - err0), 64'(exp_err));
      checkOutput("res_done_count", 64'(res_seen - res0), 64'(exp_res));
    end
  endtask

  function automatic logic [31:0] pick_value();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [7:0]  tag;
    logic [31:0] val;
    int nbytes, r;
    _rst = 1'b1;
    valid_in = 1'b0;
    startofpacket_in = 1'b0;
    endofpacket_in = 1'b0;
    data_in = 8'd0;
    ready_in = 1'b1;
    #1 _rst = 1'b0;
    #3 check_reset_outputs("reset");
    @(negedge clk);
    _rst = 1'b1;

    run_packet(TAG_A, 32'd3, 4, 0, 8);
    run_packet(TAG_B, 32'd5, 4, 0, 8);

    run_packet(TAG_B, 32'hFFFF_FFFF, 4, 0, 8);
    run_packet(TAG_A, 32'hFFFF_FFFF, 4, 0, 8);

    run_packet(TAG_A, 32'd3, 4, 1, 8);
    run_packet(TAG_B, 32'd5, 4, 1, 8);

    run_packet(8'h07, 32'hDEAD_BEEF, 4, 0, 8);
    run_packet(TAG_A, 32'hAABB_CCDD, 2, 0, 8);
    run_packet(TAG_A, 32'h0001_2345, 4, 0, 8);
    run_packet(TAG_B, 32'h0006_7890, 4, 2, 8);

    run_packet(TAG_A, 32'd2, 4, 0, 8);
    run_packet(TAG_A, 32'd9, 4, 0, 8);
    run_packet(TAG_B, 32'd3, 4, 0, 8);

    run_packet(TAG_A, 32'h1234_5678, 4, 0, 8);
    run_packet(TAG_B, 32'h9ABC_DEF0, 4, 0, 4);
    @(posedge clk);
    #2 _rst = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    _rst = 1'b1;
    ready_in = 1'b1;
    run_packet(TAG_A, 32'd1, 4, 0, 8);
    run_packet(TAG_B, 32'd1, 4, 0, 8);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      val = pick_value();
      nbytes = 4;
      if (r < 4)      tag = TAG_A;
      else if (r < 8) tag = TAG_B;
      else if (r == 8) tag = 8'($urandom_range(3, 255));
      else begin
        tag = ($urandom_range(0, 1) == 0) ? TAG_A : TAG_B;
        nbytes = $urandom_range(1, 3);
      end
      run_packet(tag, val, nbytes, $urandom_range(0, 2), 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
